// File: rtl/rsa_modexp_arbiter_if.sv
// Request/response bundle between the two modexp requesters and the arbiter.
// Macro: none here (see rsa_modexp_arbiter.sv for RSA_RR_ARB_EN).
// Signals: req0/req1 + m/e/n per port (requester -> arbiter);
//          ack0/ack1, done0/done1, result, busy (arbiter -> requester).
interface rsa_modexp_arbiter_if #(
  parameter int unsigned W = 7
);
  logic         req0;
  logic         req1;
  logic [W-1:0] m0;
  logic [W-1:0] e0;
  logic [W-1:0] n0;
  logic [W-1:0] m1;
  logic [W-1:0] e1;
  logic [W-1:0] n1;
  logic         ack0;
  logic         ack1;
  logic         done0;
  logic         done1;
  logic [W-1:0] result;
  logic         busy;

  // Requester side
  modport master (
    output req0, req1, m0, e0, n0, m1, e1, n1,
    input  ack0, ack1, done0, done1, result, busy
  );

  // Arbiter side
  modport slave (
    input  req0, req1, m0, e0, n0, m1, e1, n1,
    output ack0, ack1, done0, done1, result, busy
  );
endinterface

// File: rtl/rsa_modexp_arbiter.sv
// Two-port modular exponentiation engine with request arbitration.
// Computes m^e mod n by right-to-left square-and-multiply, one exponent bit
// per RUN cycle, for the port granted in IDLE.
// Macro: RSA_RR_ARB_EN -- defined: round-robin between ports on ties;
//        undefined (default): fixed priority, port 1 wins ties.
// Ports: clk   - clock, rising edge
//        reset - synchronous active-low reset
//        bus   - rsa_modexp_arbiter_if.slave (requests, operands, ack/done,
//                result, busy); all outputs are registered.
// The interface instance must use the same W as this module.
module rsa_modexp_arbiter #(
  parameter int unsigned W = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  rsa_modexp_arbiter_if.slave  bus
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic [W-1:0]  m_r;
  logic [W-1:0]  e_r;
  logic [W-1:0]  n_r;
  logic [W-1:0]  base;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          gnt;

`ifdef RSA_RR_ARB_EN
  // Port granted most recently; reset value 1 makes port 0 win the first tie.
  logic          last;
`endif

  logic          pick;
  logic [PW-1:0] n_x;
  logic [PW-1:0] acc_prod;
  logic [PW-1:0] base_prod;
  logic [W-1:0]  acc_mul;
  logic [W-1:0]  base_sq;
  logic [W-1:0]  base_init;
  logic [W-1:0]  acc_init;

  // Grant choice for the current IDLE cycle (1 = port 1).
  always_comb begin
    pick = bus.req1;
    if (bus.req0 && bus.req1) begin
`ifdef RSA_RR_ARB_EN
      pick = ~last;
`else
      pick = 1'b1;
`endif
    end
  end

  // Full-width products reduced in the same cycle; n = 0 forces everything to 0
  // so the modulo never divides by zero.
  always_comb begin
    n_x       = PW'(n_r);
    acc_prod  = PW'(acc) * PW'(base);
    base_prod = PW'(base) * PW'(base);
    acc_mul   = '0;
    base_sq   = '0;
    base_init = '0;
    acc_init  = '0;
    if (n_r != '0) begin
      acc_mul   = W'(acc_prod % n_x);
      base_sq   = W'(base_prod % n_x);
      base_init = m_r % n_r;
      acc_init  = (n_r == W'(1)) ? '0 : W'(1);
    end
  end

  // Control FSM, operand datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      m_r        <= '0;
      e_r        <= '0;
      n_r        <= '0;
      base       <= '0;
      acc        <= '0;
      cnt        <= '0;
      gnt        <= 1'b0;
`ifdef RSA_RR_ARB_EN
      last       <= 1'b1;
`endif
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.done0  <= 1'b0;
      bus.done1  <= 1'b0;
      bus.busy   <= 1'b0;
      bus.result <= '0;
    end else begin
      bus.ack0  <= 1'b0;
      bus.ack1  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      case (state)
        IDLE: begin
          // ack is registered here so it is visible throughout LOAD.
          if (bus.req0 || bus.req1) begin
            state    <= LOAD;
            bus.busy <= 1'b1;
            gnt      <= pick;
            bus.ack0 <= ~pick;
            bus.ack1 <= pick;
            m_r      <= pick ? bus.m1 : bus.m0;
            e_r      <= pick ? bus.e1 : bus.e0;
            n_r      <= pick ? bus.n1 : bus.n0;
`ifdef RSA_RR_ARB_EN
            last     <= pick;
`endif
          end
        end
        LOAD: begin
          state <= RUN;
          base  <= base_init;
          acc   <= acc_init;
          cnt   <= '0;
        end
        RUN: begin
          // Exponent is consumed LSB first by shifting.
          if (e_r[0]) begin
            acc <= acc_mul;
          end
          base <= base_sq;
          e_r  <= e_r >> 1;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          bus.result <= acc;
          bus.done0  <= ~gnt;
          bus.done1  <= gnt;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_arbiter.sv
// Self-checking bench for rsa_modexp_arbiter: scoreboard of expected
// (port, result) pairs pushed at stimulus time and popped on each done pulse.
module tb_rsa_modexp_arbiter;

  localparam int unsigned W = 7;
  // done is registered W+2 edges after the sampling edge; the bench counts
  // negedges starting with the one after the sampling edge.
  localparam int unsigned DONE_NEG = W + 3;

  typedef struct packed {
    logic         port;
    logic [W-1:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rsa_modexp_arbiter_if #(.W(W)) bus ();
  rsa_modexp_arbiter #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  // Straight repeated multiplication, independent of the DUT's algorithm.
  function automatic logic [W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] e,
                                         input logic [W-1:0] n);
    longint r;
    if (n <= 1) return '0;
    r = 1;
    for (int i = 0; i < int'(e); i++) r = (r * longint'(m)) % longint'(n);
    return W'(r);
  endfunction

  // Scoreboard and handshake monitor.
  always @(negedge clk) begin
    if (bus.ack0) ack_cnt0++;
    if (bus.ack1) ack_cnt1++;
    if (bus.done0) done_cnt0++;
    if (bus.done1) done_cnt1++;
    if (bus.ack0 || bus.ack1) begin
      checks++;
      if (bus.ack0 && bus.ack1) begin
        errors++;
        $display("FAIL dual_ack: ack0=%b ack1=%b, required one-hot", bus.ack0, bus.ack1);
      end
    end
    if (bus.done0 || bus.done1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done0=%b done1=%b result=%0d, none expected",
                 bus.done0, bus.done1, bus.result);
      end else begin
        mon_e = sb.pop_front();
        if ((bus.done0 && bus.done1) || bus.done1 !== mon_e.port || bus.result !== mon_e.res) begin
          errors++;
          $display("FAIL scoreboard: done0=%b done1=%b result=%0d, required port%0d result=%0d",
                   bus.done0, bus.done1, bus.result, mon_e.port, mon_e.res);
        end
      end
    end
  end

  task automatic set_req(input logic p, input logic v);
    if (p) bus.req1 = v; else bus.req0 = v;
  endtask

  task automatic set_ops(input logic p, input logic [W-1:0] m, input logic [W-1:0] e,
                         input logic [W-1:0] n);
    if (p) begin bus.m1 = m; bus.e1 = e; bus.n1 = n; end
    else   begin bus.m0 = m; bus.e0 = e; bus.n0 = n; end
  endtask

  function automatic logic ack_of(input logic p);
    return p ? bus.ack1 : bus.ack0;
  endfunction

  function automatic logic done_of(input logic p);
    return p ? bus.done1 : bus.done0;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One isolated transaction from an idle DUT; operands are scrambled after ack.
  task automatic run_op(input logic p, input logic [W-1:0] m, input logic [W-1:0] e,
                        input logic [W-1:0] n, input logic [W-1:0] expv);
    int ack_at = 0;
    int done_at = 0;
    sb.push_back('{port: p, res: expv});
    set_ops(p, m, e, n);
    set_req(p, 1'b1);
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      @(negedge clk);
      if (ack_at == 0 && ack_of(p)) begin
        ack_at = c;
        set_req(p, 1'b0);
        set_ops(p, W'($urandom), W'($urandom), W'($urandom));
      end
      if (done_of(p)) done_at = c;
    end
    checks++;
    if (ack_at != 1) begin
      errors++;
      $display("FAIL ack_latency port%0d: got %0d, required 1", p, ack_at);
    end
    checks++;
    if (done_at != int'(DONE_NEG)) begin
      errors++;
      $display("FAIL done_latency port%0d: got %0d, required %0d", p, done_at, DONE_NEG);
    end
    @(negedge clk);
    checks++;
    if (bus.result !== expv) begin
      errors++;
      $display("FAIL result_hold port%0d: got %0d, required %0d", p, bus.result, expv);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.ack0, bus.ack1, bus.done0, bus.done1} !== 5'b0 || bus.result !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b ack=%b%b done=%b%b result=%0d, required all 0",
               bus.busy, bus.ack0, bus.ack1, bus.done0, bus.done1, bus.result);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b, required 0", bus.busy);
    end
  endtask

  task automatic test_vectors();
    run_op(1'b0, 7'd9, 7'd7, 7'd77, 7'd37);
    run_op(1'b1, 7'd37, 7'd43, 7'd77, 7'd9);
    run_op(1'b0, 7'd5, 7'd0, 7'd77, 7'd1);
    run_op(1'b1, 7'd5, 7'd3, 7'd1, 7'd0);
    run_op(1'b0, 7'd5, 7'd3, 7'd0, 7'd0);
    run_op(1'b1, 7'd100, 7'd1, 7'd77, 7'd23);
  endtask

  task automatic test_random();
    logic [W-1:0] m, e, n;
    for (int i = 0; i < 6; i++) begin
      m = W'($urandom);
      e = W'($urandom);
      n = W'($urandom_range(2, 127));
      run_op(1'(i), m, e, n, model(m, e, n));
    end
  endtask

  task automatic test_simultaneous();
    int a0, a1, d0, d1;
    bit got0 = 1'b0;
    bit got1 = 1'b0;
    do_reset();
    a0 = ack_cnt0; a1 = ack_cnt1; d0 = done_cnt0; d1 = done_cnt1;
`ifdef RSA_RR_ARB_EN
    sb.push_back('{port: 1'b0, res: 7'd37});
    sb.push_back('{port: 1'b1, res: 7'd9});
`else
    sb.push_back('{port: 1'b1, res: 7'd9});
    sb.push_back('{port: 1'b0, res: 7'd37});
`endif
    set_ops(1'b0, 7'd9, 7'd7, 7'd77);
    set_ops(1'b1, 7'd37, 7'd43, 7'd77);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int c = 0; c < 60 && !(got0 && got1); c++) begin
      @(negedge clk);
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
      if (bus.done0) got0 = 1'b1;
      if (bus.done1) got1 = 1'b1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (ack_cnt0 - a0 != 1 || ack_cnt1 - a1 != 1) begin
      errors++;
      $display("FAIL tie_acks: ack0 x%0d ack1 x%0d, required 1 each", ack_cnt0 - a0, ack_cnt1 - a1);
    end
    checks++;
    if (done_cnt0 - d0 != 1 || done_cnt1 - d1 != 1) begin
      errors++;
      $display("FAIL tie_dones: done0 x%0d done1 x%0d, required 1 each",
               done_cnt0 - d0, done_cnt1 - d1);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    int ack_at = 0;
    set_ops(1'b0, 7'd9, 7'd7, 7'd77);
    bus.req0 = 1'b1;
    for (int c = 1; c <= 5 && ack_at == 0; c++) begin
      @(negedge clk);
      if (bus.ack0) ack_at = c;
    end
    bus.req0 = 1'b0;
    checks++;
    if (ack_at == 0) begin
      errors++;
      $display("FAIL abort_ack: got none, required ack0");
    end
    repeat (4) @(negedge clk);  // now in RUN cycle 3
    d0 = done_cnt0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: busy=%b done0=%b, required 0 0", bus.busy, bus.done0);
    end
    reset = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (done_cnt0 != d0) begin
      errors++;
      $display("FAIL abort_done: got %0d done0 pulses, required 0", done_cnt0 - d0);
    end
    run_op(1'b0, 7'd9, 7'd7, 7'd77, 7'd37);
  endtask

  task automatic test_pending();
    int done0_at = 0;
    int ack1_at = 0;
    int a1;
    bit got1 = 1'b0;
    a1 = ack_cnt1;
    sb.push_back('{port: 1'b0, res: 7'd37});
    sb.push_back('{port: 1'b1, res: 7'd9});
    set_ops(1'b0, 7'd9, 7'd7, 7'd77);
    bus.req0 = 1'b1;
    for (int c = 1; c <= 60 && !got1; c++) begin
      @(negedge clk);
      if (bus.ack0) bus.req0 = 1'b0;
      if (c == 3) begin
        set_ops(1'b1, 7'd37, 7'd43, 7'd77);
        bus.req1 = 1'b1;
      end
      if (bus.done0 && done0_at == 0) done0_at = c;
      if (bus.ack1 && ack1_at == 0) begin
        ack1_at = c;
        bus.req1 = 1'b0;
      end
      if (bus.done1) got1 = 1'b1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (done0_at == 0 || ack1_at != done0_at + 1) begin
      errors++;
      $display("FAIL pending_ack: ack1 at %0d, required %0d", ack1_at, done0_at + 1);
    end
    checks++;
    if (!got1 || ack_cnt1 - a1 != 1) begin
      errors++;
      $display("FAIL pending_done: done1=%b acks=%0d, required 1 1", got1, ack_cnt1 - a1);
    end
  endtask

  task automatic test_withdraw();
    int a1, d1;
    bit got0 = 1'b0;
    a1 = ack_cnt1;
    d1 = done_cnt1;
    sb.push_back('{port: 1'b0, res: 7'd1});
    set_ops(1'b0, 7'd3, 7'd0, 7'd10);
    bus.req0 = 1'b1;
    for (int c = 1; c <= 40 && !got0; c++) begin
      @(negedge clk);
      if (bus.ack0) bus.req0 = 1'b0;
      if (c == 3) begin
        set_ops(1'b1, 7'd4, 7'd5, 7'd11);
        bus.req1 = 1'b1;
      end
      if (c == 5) bus.req1 = 1'b0;
      if (bus.done0) got0 = 1'b1;
    end
    repeat (12) @(negedge clk);
    checks++;
    if (!got0 || ack_cnt1 != a1 || done_cnt1 != d1) begin
      errors++;
      $display("FAIL withdraw: done0=%b ack1 x%0d done1 x%0d, required 1 0 0",
               got0, ack_cnt1 - a1, done_cnt1 - d1);
    end
  endtask

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    set_ops(1'b0, '0, '0, '0);
    set_ops(1'b1, '0, '0, '0);
    test_reset();
    test_vectors();
    test_random();
    test_simultaneous();
    test_reset_abort();
    test_pending();
    test_withdraw();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
